// File: rtl/apb_master_bridge_if.sv
// Bundles the core-side request/response channel and the APB3 bus of apb_master_bridge.
// The master modport is the bridge's view and the slave modport is the environment's view.
interface apb_master_bridge_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [APB_ADDR_WIDTH-1:0] req_addr;
    logic [31:0]               req_wdata;
    logic                      req_write;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: one valid/ready request becomes one APB transfer.
// Optional ACCESS-phase abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                    state_reg;
    logic [APB_ADDR_WIDTH-1:0] paddr_reg;
    logic [31:0]               pwdata_reg;
    logic                      pwrite_reg;
    logic                      psel_reg;
    logic                      penable_reg;
    logic                      rsp_valid_reg;
    logic [31:0]               rsp_rdata_reg;
    logic                      rsp_err_reg;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
            $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds (ACCESS cycle index - 1), so this value marks the last allowed cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] access_cnt_reg;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg     <= S_IDLE;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pwrite_reg    <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            access_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error and leave the APB bus untouched.
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                            state_reg     <= S_RESP;
                        end else begin
                            paddr_reg  <= bus.req_addr;
                            pwdata_reg <= bus.req_wdata;
                            pwrite_reg <= bus.req_write;
                            psel_reg   <= 1'b1;
                            state_reg  <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    access_cnt_reg <= '0;
`endif
                end

                S_ACCESS: begin
                    if (bus.PREADY) begin
                        rsp_rdata_reg <= pwrite_reg ? 32'h0 : bus.PRDATA;
                        rsp_err_reg   <= bus.PSLVERR;
                        rsp_valid_reg <= 1'b1;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        state_reg     <= S_RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (access_cnt_reg == CNT_LAST) begin
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        state_reg     <= S_RESP;
                    end else begin
                        access_cnt_reg <= access_cnt_reg + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.PADDR     = paddr_reg;
    assign bus.PWDATA    = pwdata_reg;
    assign bus.PWRITE    = pwrite_reg;
    assign bus.PSEL      = psel_reg;
    assign bus.PENABLE   = penable_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule
